// File: rtl/mem_access_if.sv
// Request/response and memory-side signal bundle for mem_access_controller.
// slave = the controller; master = requester plus the word-array memory.
interface mem_access_if #(
  parameter int BITS              = 64,
  parameter int ADDRESS_BUS_WIDTH = 6,
  parameter int LEN_WIDTH         = 4
);
  logic                         ReqValid;
  logic                         ReqReady;
  logic                         ReqWrite;
  logic [ADDRESS_BUS_WIDTH-1:0] ReqAddress;
  logic [BITS-1:0]              ReqData;
  logic [LEN_WIDTH-1:0]         ReqLen;
  logic                         RespValid;
  logic                         RespReady;
  logic [BITS-1:0]              RespData;
  logic                         WriteDone;
  logic                         WriteError;
  logic [BITS-1:0]              MemD;
  logic [ADDRESS_BUS_WIDTH-1:0] MemAddress;
  logic                         MemWE;
  logic [BITS-1:0]              MemQ;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqData, ReqLen, RespReady, MemQ,
    output ReqReady, RespValid, RespData, WriteDone, WriteError, MemD, MemAddress, MemWE
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqData, ReqLen, RespReady, MemQ,
    input  ReqReady, RespValid, RespData, WriteDone, WriteError, MemD, MemAddress, MemWE
  );
endinterface

// File: rtl/mem_access_controller.sv
// Sequencer in front of a combinational-read word array: single writes, burst reads.
// Optional write readback check is enabled by defining MEM_ACCESS_VERIFY_EN.
module mem_access_controller #(
  parameter int BITS              = 64,
  parameter int ADDRESS_BUS_WIDTH = 6,
  parameter int LEN_WIDTH         = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  mem_access_if.slave   bus
);

`ifdef MEM_ACCESS_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, VERIFY} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP} state_t;
`endif

  state_t                       state, next_state;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q;
  logic [BITS-1:0]              data_q;
  logic [LEN_WIDTH-1:0]         rem_q;
  logic [BITS-1:0]              resp_data_q;
  logic                         resp_valid_q;
  logic                         write_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.ReqValid) next_state = bus.ReqWrite ? WRITE : READ;
`ifdef MEM_ACCESS_VERIFY_EN
      WRITE:  next_state = VERIFY;
      VERIFY: next_state = IDLE;
`else
      WRITE:  next_state = IDLE;
`endif
      READ:   next_state = RESP;
      RESP:   if (bus.RespReady) next_state = (rem_q == '0) ? IDLE : READ;
      default: next_state = IDLE;
    endcase
  end

`ifdef MEM_ACCESS_VERIFY_EN
  logic write_error_q;

  always_ff @(posedge CLK) begin
    if (Reset) write_error_q <= 1'b0;
    else       write_error_q <= (state == VERIFY) && (bus.MemQ != data_q);
  end

  assign bus.WriteError = write_error_q;
`else
  assign bus.WriteError = 1'b0;
`endif

  // NOTE: datapath registers are reset too, so MemD/MemAddress/RespData
  // leave reset at 0 rather than holding stale or unknown words.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      addr_q       <= '0;
      data_q       <= '0;
      rem_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      write_done_q <= 1'b0;
    end else begin
      write_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            addr_q <= bus.ReqAddress;
            rem_q  <= bus.ReqLen;
            // MemD keeps the last write word, so reads leave data_q alone.
            if (bus.ReqWrite) data_q <= bus.ReqData;
          end
        end
`ifdef MEM_ACCESS_VERIFY_EN
        VERIFY: write_done_q <= 1'b1;
`else
        WRITE:  write_done_q <= 1'b1;
`endif
        READ: begin
          resp_data_q  <= bus.MemQ;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.RespReady) begin
            resp_valid_q <= 1'b0;
            if (rem_q != '0) begin
              addr_q <= addr_q + 1'b1;
              rem_q  <= rem_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ReqReady   = (state == IDLE);
  assign bus.MemWE      = (state == WRITE);
  assign bus.MemAddress = addr_q;
  assign bus.MemD       = data_q;
  assign bus.RespData   = resp_data_q;
  assign bus.RespValid  = resp_valid_q;
  assign bus.WriteDone  = write_done_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with a behavioural word-array memory
// and a queue scoreboard for read responses.
module tb_mem_access_controller;
  localparam int BITS = 64;
  localparam int AW   = 6;
  localparam int LW   = 4;

  logic clk;
  logic rst;

  mem_access_if #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  mem_access_controller #(.BITS(BITS), .ADDRESS_BUS_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the edge while WE is high.
  logic [BITS-1:0] mem [2**AW];
  assign bus.MemQ = mem[bus.MemAddress];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (bus.MemWE) begin
`ifdef MEM_ACCESS_VERIFY_EN
      if (bus.MemAddress == 6'd3 && bus.MemD == 64'hFF) mem[bus.MemAddress] <= bus.MemD ^ 64'h1;
      else                                              mem[bus.MemAddress] <= bus.MemD;
`else
      mem[bus.MemAddress] <= bus.MemD;
`endif
    end
  end

  logic [BITS-1:0] model [2**AW];
  logic [BITS-1:0] sb [$];
  int total  = 0;
  int passed = 0;
  int failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [BITS-1:0] d,
                          input logic [LW-1:0] len);
    check("req_ready_idle", bus.ReqReady, 1);
    bus.ReqValid   = 1'b1;
    bus.ReqWrite   = wr;
    bus.ReqAddress = a;
    bus.ReqData    = d;
    bus.ReqLen     = len;
    tick();
    bus.ReqValid   = 1'b0;
    bus.ReqWrite   = 1'b0;
    bus.ReqData    = '0;
    bus.ReqLen     = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [BITS-1:0] d, input logic exp_err);
    model[a] = d;
    send_req(1'b1, a, d, '0);
    check("wr_we",         bus.MemWE, 1);
    check("wr_addr",       bus.MemAddress, a);
    check("wr_d",          bus.MemD, d);
    check("wr_busy",       bus.ReqReady, 0);
    check("wr_done_early", bus.WriteDone, 0);
`ifdef MEM_ACCESS_VERIFY_EN
    tick();
    check("vf_we",         bus.MemWE, 0);
    check("vf_addr",       bus.MemAddress, a);
    check("vf_busy",       bus.ReqReady, 0);
    check("vf_done_early", bus.WriteDone, 0);
`endif
    tick();
    check("wr_we_drop", bus.MemWE, 0);
    check("wr_done",    bus.WriteDone, 1);
    check("wr_err",     bus.WriteError, exp_err);
    check("wr_ready",   bus.ReqReady, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len,
                         input int stall_word, input int stall_n);
    logic [AW-1:0]   wa;
    logic [BITS-1:0] exp;
    int              waited;
    for (int i = 0; i <= int'(len); i++) begin
      wa = a + AW'(i);
      sb.push_back(model[wa]);
    end
    send_req(1'b0, a, '0, len);
    check("rd_accept_valid_low", bus.RespValid, 0);
    for (int w = 0; w <= int'(len); w++) begin
      waited = 0;
      while (!bus.RespValid && waited < 8) begin
        tick();
        waited++;
      end
      if (!bus.RespValid) begin
        check("rd_timeout", 0, 1);
        sb.delete();
        return;
      end
      check("rd_latency", waited, 1);
      wa = a + AW'(w);
      check("rd_addr", bus.MemAddress, wa);
      exp = sb.pop_front();
      check("rd_data", bus.RespData, exp);
      check("rd_we_low", bus.MemWE, 0);
      if (w == stall_word) begin
        bus.RespReady = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("stall_valid", bus.RespValid, 1);
          check("stall_data",  bus.RespData, exp);
          check("stall_addr",  bus.MemAddress, wa);
        end
        bus.RespReady = 1'b1;
      end
      tick();
      check("rd_valid_drop", bus.RespValid, 0);
    end
    check("rd_idle_ready", bus.ReqReady, 1);
    check("rd_sb_empty", sb.size(), 0);
  endtask

  initial begin
    bus.ReqValid   = 1'b0;
    bus.ReqWrite   = 1'b0;
    bus.ReqAddress = '0;
    bus.ReqData    = '0;
    bus.ReqLen     = '0;
    bus.RespReady  = 1'b1;
    for (int i = 0; i < 2**AW; i++) model[i] = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_ready",  bus.ReqReady, 1);
    check("rst_resp_valid", bus.RespValid, 0);
    check("rst_resp_data",  bus.RespData, 0);
    check("rst_write_done", bus.WriteDone, 0);
    check("rst_write_err",  bus.WriteError, 0);
    check("rst_mem_d",      bus.MemD, 0);
    check("rst_mem_addr",   bus.MemAddress, 0);
    check("rst_mem_we",     bus.MemWE, 0);

    // Single write then single read of the same word.
    do_write(6'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
    tick();
    check("wr_done_pulse_end", bus.WriteDone, 0);
    check("wr_memd_hold",      bus.MemD, 64'h0123_4567_89AB_CDEF);
    check("wr_addr_hold",      bus.MemAddress, 5);
    do_read(6'd5, 4'd0, -1, 0);
    check("rd_memd_hold", bus.MemD, 64'h0123_4567_89AB_CDEF);

    // Prefill across the top of the array, then wrapped burst reads.
    do_write(6'd62, 64'hA, 1'b0);
    do_write(6'd63, 64'hB, 1'b0);
    do_write(6'd0,  64'hC, 1'b0);
    do_write(6'd1,  64'hD, 1'b0);
    do_read(6'd62, 4'd3, -1, 0);
    do_read(6'd62, 4'd3, 2, 5);
    do_read(6'd60, 4'hF, -1, 0);

    // Reset in RESP on word 1 of 4 aborts the burst.
    sb.delete();
    send_req(1'b0, 6'd62, '0, 4'd3);
    tick();
    check("mid_valid", bus.RespValid, 1);
    check("mid_data",  bus.RespData, 64'hA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid",  bus.RespValid, 0);
    check("abort_we",     bus.MemWE, 0);
    check("abort_ready",  bus.ReqReady, 1);
    check("abort_data",   bus.RespData, 0);
    check("abort_addr",   bus.MemAddress, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_resume", bus.RespValid, 0);
    end
    // Memory was cleared with the reset; refill and read back.
    do_write(6'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int i = 0; i < 2**AW; i++) if (i != 5) model[i] = '0;
    do_read(6'd5, 4'd0, -1, 0);

`ifdef MEM_ACCESS_VERIFY_EN
    do_write(6'd3, 64'hFF, 1'b1);
    do_write(6'd4, 64'hFF, 1'b0);
`else
    do_write(6'd3, 64'hFF, 1'b0);
    do_write(6'd4, 64'hFF, 1'b0);
`endif
    tick();
    check("final_err_low", bus.WriteError, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sequencer that sits directly upstream of the word-array memory and is the only block driving its D, Address and WE inputs.
- Accepts single-word write requests and burst read requests over a valid/ready request channel.
- Drives the memory's address, data and write-enable, and returns read words over a valid/ready response channel.
- Memory read path is combinational (Q follows Address); the memory write commits the word selected by Address while WE is high.

Parameters:
BITS, 64, word width; must match the memory.
ADDRESS_BUS_WIDTH, 6, memory address width; the memory holds 2^ADDRESS_BUS_WIDTH words.
LEN_WIDTH, 4, width of the burst length field; a read burst is up to 2^LEN_WIDTH words.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
Reset  in  1  synchronous, active-high reset.
ReqValid  in  1  request present.
ReqReady  out  1  controller accepts a request this cycle.
ReqWrite  in  1  1 = write, 0 = read.
ReqAddress  in  ADDRESS_BUS_WIDTH  start address.
ReqData  in  BITS  write data; ignored for reads.
ReqLen  in  LEN_WIDTH  read burst length minus 1; ignored for writes.
RespValid  out  1  RespData holds a read word.
RespReady  in  1  consumer takes the word.
RespData  out  BITS  registered read word.
WriteDone  out  1  one-cycle pulse when a write completes.
WriteError  out  1  one-cycle pulse on readback mismatch (Optional Feature only).
MemD  out  BITS  to memory D.
MemAddress  out  ADDRESS_BUS_WIDTH  to memory Address.
MemWE  out  1  to memory WE.
MemQ  in  BITS  from memory Q.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on the Reset port.
- Reset values:
  - state IDLE; ReqReady=1.
  - RespValid, RespData, WriteDone, WriteError, MemD, MemAddress and MemWE all 0.
  - Internal address and remaining-count registers 0.
- Reset during any state aborts the operation at that edge:
  - MemWE is 0 from the next cycle.
  - A pending response is dropped.
  - A partially completed burst is not resumed.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- States: IDLE, WRITE, READ, RESP (plus VERIFY with the Optional Feature).
- IDLE:
  - ReqReady=1.
  - On ReqValid&ReqReady: latch ReqAddress, ReqData, ReqWrite and ReqLen into internal registers (rem), then go to WRITE if ReqWrite=1, else READ.
  - ReqReady=0 in every other state.
- WRITE (exactly 1 cycle): MemAddress=addr, MemD=data, MemWE=1.
  - Without the feature: go to IDLE and pulse WriteDone for 1 cycle, coincident with IDLE.
  - Write latency: request accept edge to WriteDone is 2 cycles.
- MemWE is high only in WRITE and never for more than 1 consecutive cycle per request.
- READ (1 cycle):
  - MemWE=0, MemAddress=addr.
  - At the edge, capture MemQ into RespData, set RespValid=1, go to RESP.
- RESP:
  - Hold RespData and RespValid stable until RespReady=1.
  - On handshake with rem==0: clear RespValid, go to IDLE.
  - On handshake with rem!=0: addr<=addr+1 modulo 2^ADDRESS_BUS_WIDTH (wraps from all-ones to 0), rem<=rem-1, clear RespValid, go to READ.
- Read timing:
  - First word: RespValid rises 2 edges after request accept.
  - Burst throughput: 1 word per 2 cycles when RespReady is held high.
- Burst length: ReqLen=0 gives 1 word; all-ones gives 2^LEN_WIDTH words. Burst wrap past the top address is legal and silent.
- RespReady while RespValid=0 has no effect.
- ReqValid while ReqReady=0 is ignored; the requester must hold the request until ReqReady.
- Back-to-back requests: a new request can be accepted on the first IDLE cycle after completion. IDLE lasts at least 1 cycle between requests.
- MemD holds the last write data and MemAddress holds the last driven address when not writing.

Optional Feature:
- Macro: MEM_ACCESS_VERIFY_EN.
- When defined:
  - WRITE goes to VERIFY instead of IDLE.
  - VERIFY (1 cycle): MemWE=0, MemAddress=addr. Compare MemQ to the latched data, then go to IDLE.
  - WriteDone pulses at IDLE entry; WriteError pulses in the same cycle if the compare mismatched.
  - Write latency becomes 3 cycles.
- When undefined: no VERIFY state; WriteError is tied to 0.

Test Plan:
- Reset, then write addr 5, data 0x0123_4567_89AB_CDEF -> MemWE=1 for exactly 1 cycle with MemAddress=5; WriteDone pulses 2 cycles after accept; ReqReady=0 meanwhile.
- Read addr 5, ReqLen=0, RespReady=1 -> RespValid high 2 edges after accept with RespData=0x0123_4567_89AB_CDEF; returns to IDLE; ReqReady=1.
- Prefill addrs 62, 63, 0, 1 with 0xA, 0xB, 0xC, 0xD, then read addr 62 with ReqLen=3 -> responses 0xA, 0xB, 0xC, 0xD in order; MemAddress wraps 63->0.
- Burst read with RespReady held low 5 cycles on word 2 -> RespData and RespValid stable all 5 cycles; no address advance; no lost or duplicated words.
- Reset asserted in RESP mid-burst (word 1 of 4) -> next cycle RespValid=0, MemWE=0, ReqReady=1; a subsequent single read returns correct data.
- With MEM_ACCESS_VERIFY_EN, force the memory model to corrupt bit 0 on write of 0xFF to addr 3 -> WriteDone and WriteError pulse together 3 cycles after accept; uncorrupted write gives WriteError=0.
